reaction_round_ctrl: RTL

//  Parametrised multi-player, multi-round reaction-game core; successor to the single-player, single-shot game FSM.

---
 rtl/reaction_round_ctrl_pkg.sv | 23 ++
 rtl/reaction_round_ctrl_if.sv | 37 +++
 rtl/reaction_round_ctrl_lfsr.sv | 23 ++
 rtl/reaction_round_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/reaction_round_ctrl_pkg.sv
// Shared definitions for the reaction-round game: state codes, LFSR shape and step function.
// The single-player game FSM uses the same state encoding.
package reaction_round_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_COUNTDOWN = 3'd1,
      ST_WAIT      = 3'd2,
      ST_GO        = 3'd3,
      ST_ROUND_END = 3'd4,
      ST_DONE      = 3'd5
   } state_t;

   localparam int LFSR_W = 9;

   // Galois taps for x^9 + x^5 + 1 in right-shift form
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 9'h110;

   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
      return {1'b0, q[LFSR_W-1:1]} ^ (q[0] ? LFSR_TAPS : '0);
   endfunction

endpackage

// File: rtl/reaction_round_ctrl_if.sv
// Game-side signal bundle: tick/button/control inputs towards the core, round results towards the screens.
interface reaction_round_ctrl_if #(
   parameter int NUM_PLAYERS = 2,
   parameter int NUM_ROUNDS  = 4,
   parameter int CNT_W       = 9
);
   localparam int RND_W = $clog2(NUM_ROUNDS) + 1;
   localparam int TOT_W = CNT_W + $clog2(NUM_ROUNDS);
   localparam int WIN_W = $clog2(NUM_PLAYERS) + 1;

   logic                         enable;
   logic                         tick_100hz;
   logic                         tick_1hz;
   logic                         start;
   logic [NUM_PLAYERS-1:0]       btn;
   logic [CNT_W-1:0]             seed;
   logic [2:0]                   state_o;
   logic [2:0]                   countdown;
   logic                         go;
   logic [RND_W-1:0]             round_idx;
   logic [NUM_PLAYERS-1:0]       foul;
   logic [NUM_PLAYERS*CNT_W-1:0] react_time;
   logic [NUM_PLAYERS*TOT_W-1:0] total;
   logic [WIN_W-1:0]             winner;
   logic                         winner_vld;
   logic                         done;

   modport master (
      output enable, tick_100hz, tick_1hz, start, btn, seed,
      input  state_o, countdown, go, round_idx, foul, react_time, total, winner, winner_vld, done
   );

   modport slave (
      input  enable, tick_100hz, tick_1hz, start, btn, seed,
      output state_o, countdown, go, round_idx, foul, react_time, total, winner, winner_vld, done
   );
endinterface

// File: rtl/reaction_round_ctrl_lfsr.sv
// Free-running 9-bit Galois LFSR advanced by a tick enable; a load never leaves it stuck at zero.
module reaction_round_ctrl_lfsr
   import reaction_round_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              step,
   input  logic              load,
   input  logic [LFSR_W-1:0] load_val,
   output logic [LFSR_W-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= LFSR_W'(1);
      end else if (load) begin
         q <= (load_val == '0) ? LFSR_W'(1) : load_val;
      end else if (step) begin
         q <= lfsr_next(q);
      end
   end

endmodule

// File: rtl/reaction_round_ctrl.sv
// Multi-player, multi-round reaction game core: countdown, random hold-off, GO window and capture,
// with per-player fouls, reaction times, running totals and a per-round winner.
module reaction_round_ctrl
   import reaction_round_ctrl_pkg::*;
#(
   parameter int NUM_PLAYERS = 2,
   parameter int NUM_ROUNDS  = 4,
   parameter int CNT_W       = 9,
   parameter int TIMEOUT     = 300,
   parameter int MIN_DELAY   = 100,
   parameter int COUNTDOWN_S = 5
) (
   input logic               clk,
   input logic               rst,
   reaction_round_ctrl_if.slave bus
);

   localparam int RND_W = $clog2(NUM_ROUNDS) + 1;
   localparam int TOT_W = CNT_W + $clog2(NUM_ROUNDS);
   localparam int WIN_W = $clog2(NUM_PLAYERS) + 1;
   localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] MIN_V     = CNT_W'(MIN_DELAY);
   localparam logic [2:0]       CD_V      = 3'(COUNTDOWN_S);
   localparam logic [RND_W-1:0] LAST_RND  = RND_W'(NUM_ROUNDS - 1);
   localparam logic [WIN_W-1:0] NO_WIN    = WIN_W'(NUM_PLAYERS);

   state_t                 state, state_nxt;
   logic [2:0]             countdown_q;
   logic [CNT_W-1:0]       delay_q, timer_q, delay_init, lfsr_cnt, best;
   logic [RND_W-1:0]       round_q;
   logic [NUM_PLAYERS-1:0] btn_q, press_q, foul_q, capt_q, capt_now;
   logic [CNT_W-1:0]       react_q [NUM_PLAYERS];
   logic [TOT_W-1:0]       total_q [NUM_PLAYERS];
   logic [WIN_W-1:0]       winner_q, winner_c;
   logic [LFSR_W-1:0]      lfsr_q;
   logic                   start_ok, all_fouled, go_exit;
   logic [NUM_PLAYERS*CNT_W-1:0] react_flat;
   logic [NUM_PLAYERS*TOT_W-1:0] total_flat;

   assign start_ok   = bus.start & bus.enable & ((state == ST_IDLE) | (state == ST_DONE));
   assign lfsr_cnt   = CNT_W'(lfsr_q);
   assign delay_init = (lfsr_cnt < MIN_V) ? lfsr_cnt + MIN_V : lfsr_cnt;
   assign capt_now   = press_q & ~foul_q & ~capt_q;
   assign all_fouled = &(foul_q | press_q);
   assign go_exit    = (&(foul_q | capt_q | capt_now)) | (timer_q == TIMEOUT_V);

   reaction_round_ctrl_lfsr u_lfsr (
      .clk      (clk),
      .rst      (rst),
      .step     (bus.tick_100hz),
      .load     (start_ok),
      .load_val (lfsr_q ^ LFSR_W'(bus.seed)),
      .q        (lfsr_q)
   );

   // Presses are rising edges of the button levels, registered so they land one cycle after btn
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_q   <= '0;
         press_q <= '0;
      end else begin
         btn_q   <= bus.btn;
         press_q <= bus.btn & ~btn_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (!bus.enable) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: if (bus.start) state_nxt = ST_COUNTDOWN;
            ST_COUNTDOWN:     if (bus.tick_1hz && countdown_q <= 3'd1) state_nxt = ST_WAIT;
            ST_WAIT: begin
               if (all_fouled)                              state_nxt = ST_ROUND_END;
               else if (bus.tick_100hz && delay_q <= CNT_W'(1)) state_nxt = ST_GO;
            end
            ST_GO:            if (go_exit) state_nxt = ST_ROUND_END;
            ST_ROUND_END:     state_nxt = (round_q == LAST_RND) ? ST_DONE : ST_COUNTDOWN;
            default:          state_nxt = ST_IDLE;
         endcase
      end
   end

   // Strict less-than scanning upwards gives ties to the lowest index; TIMEOUT is never a winner
   always_comb begin
      best     = TIMEOUT_V;
      winner_c = NO_WIN;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         if (!foul_q[i] && react_q[i] < best) begin
            best     = react_q[i];
            winner_c = WIN_W'(i);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         countdown_q <= '0;
         delay_q     <= '0;
         timer_q     <= '0;
         round_q     <= '0;
         foul_q      <= '0;
         capt_q      <= '0;
         winner_q    <= '0;
         for (int i = 0; i < NUM_PLAYERS; i++) begin
            react_q[i] <= '0;
            total_q[i] <= '0;
         end
      end else if (!bus.enable) begin
         countdown_q <= '0;
         delay_q     <= '0;
         timer_q     <= '0;
         round_q     <= '0;
         foul_q      <= '0;
         capt_q      <= '0;
         winner_q    <= '0;
         for (int i = 0; i < NUM_PLAYERS; i++) begin
            react_q[i] <= '0;
            total_q[i] <= '0;
         end
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (bus.start) begin
                  countdown_q <= CD_V;
                  round_q     <= '0;
                  foul_q      <= '0;
                  capt_q      <= '0;
                  winner_q    <= '0;
                  for (int i = 0; i < NUM_PLAYERS; i++) begin
                     react_q[i] <= '0;
                     total_q[i] <= '0;
                  end
               end
            end
            ST_COUNTDOWN: begin
               if (bus.tick_1hz) begin
                  if (countdown_q <= 3'd1) begin
                     countdown_q <= '0;
                     delay_q     <= delay_init;
                  end else begin
                     countdown_q <= countdown_q - 3'd1;
                  end
               end
            end
            ST_WAIT: begin
               timer_q <= '0;
               if (bus.tick_100hz && delay_q > CNT_W'(1)) delay_q <= delay_q - CNT_W'(1);
               for (int i = 0; i < NUM_PLAYERS; i++) begin
                  if (press_q[i]) begin
                     foul_q[i]  <= 1'b1;
                     react_q[i] <= TIMEOUT_V;
                  end
               end
            end
            ST_GO: begin
               if (bus.tick_100hz && timer_q < TIMEOUT_V) timer_q <= timer_q + CNT_W'(1);
               capt_q <= capt_q | capt_now;
               for (int i = 0; i < NUM_PLAYERS; i++) begin
                  if (capt_now[i])                             react_q[i] <= timer_q;
                  else if (go_exit && !capt_q[i] && !foul_q[i]) react_q[i] <= TIMEOUT_V;
               end
            end
            ST_ROUND_END: begin
               winner_q <= winner_c;
               for (int i = 0; i < NUM_PLAYERS; i++) total_q[i] <= total_q[i] + TOT_W'(react_q[i]);
               if (round_q != LAST_RND) begin
                  round_q     <= round_q + RND_W'(1);
                  foul_q      <= '0;
                  capt_q      <= '0;
                  countdown_q <= CD_V;
                  for (int i = 0; i < NUM_PLAYERS; i++) react_q[i] <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      react_flat = '0;
      total_flat = '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         react_flat[i*CNT_W +: CNT_W] = react_q[i];
         total_flat[i*TOT_W +: TOT_W] = total_q[i];
      end
   end

   // The winner is shown live during ROUND_END and held from the register afterwards
   assign bus.state_o    = state;
   assign bus.countdown  = countdown_q;
   assign bus.go         = (state == ST_GO);
   assign bus.round_idx  = round_q;
   assign bus.foul       = foul_q;
   assign bus.react_time = react_flat;
   assign bus.total      = total_flat;
   assign bus.winner     = (state == ST_ROUND_END) ? winner_c : winner_q;
   assign bus.winner_vld = (state == ST_ROUND_END);
   assign bus.done       = (state == ST_DONE);

endmodule
